rob_commit_ctrl: RTL and testbench

In-order retirement sequencer for the reorder buffer. Each cycle it inspects the ROB head window and decides how many entries to dequeue. It writes the retirement register file (RRF) for each committed destination. Stores are serialized through a request/ack handshake with the memory unit, and a committed branch mispredict raises a pipeline flush followed by a hold-off window.

---
 rtl/rv32i_types.sv | 21 ++
 rtl/rob_commit_ctrl_if.sv | 11 +
 rtl/rob_commit_ctrl.sv | 150 +++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the ROB entry layout and the commit sequencer state.
package rv32i_types;

  localparam int PR_BITS_P = 6;

  typedef struct packed {
    logic                 ready;
    logic [4:0]           rd;
    logic [PR_BITS_P-1:0] pd;
    logic                 is_store;
    logic                 br_mispredict;
    logic [31:0]          br_target;
  } rob_entry_t;

  typedef enum logic [1:0] {
    COMMIT,
    STORE_WAIT,
    FLUSH
  } commit_state_t;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Commit-store handshake between the retirement sequencer and the memory unit.
interface rob_commit_ctrl_if #(
    parameter int DEPTH_BITS = 3
);
    logic                  store_req;
    logic [DEPTH_BITS-1:0] store_rob_id;
    logic                  store_ack;

    modport master (output store_req, output store_rob_id, input store_ack);
    modport slave  (input store_req, input store_rob_id, output store_ack);
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order ROB retirement sequencer with store serialization and mispredict flush.
// Optional commit monitor ports enabled by defining ROB_COMMIT_MONITOR_EN.
module rob_commit_ctrl
    import rv32i_types::*;
#(
    parameter int NSIZE      = 2,
    parameter int DEPTH_BITS = 3,
    parameter int PR_BITS    = PR_BITS_P,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  rob_entry_t            rob_head [NSIZE],
    input  logic [DEPTH_BITS:0]   rob_elemcount,
    input  logic [DEPTH_BITS-1:0] rob_tail,
    output logic [NSIZE-1:0]      rob_dequeue,
    output logic [NSIZE-1:0]      rrf_we,
    output logic [4:0]            rrf_rd [NSIZE],
    output logic [PR_BITS-1:0]    rrf_pd [NSIZE],
    rob_commit_ctrl_if.master     st,
    output logic                  flush,
    output logic [31:0]           flush_pc
`ifdef ROB_COMMIT_MONITOR_EN
    ,
    output logic [NSIZE-1:0]      mon_valid,
    output logic [63:0]           mon_order [NSIZE]
`endif
);

    localparam int HW = $clog2(FLUSH_HOLD + 1);

    commit_state_t         state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  store_req_q, store_req_d;
    logic [DEPTH_BITS-1:0] store_id_q, store_id_d;
    logic                  flush_q, flush_d;
    logic [31:0]           flush_pc_q, flush_pc_d;

    // NOTE: every comb output gets a default before any branch, so no latches are inferred.
    always_comb begin
        logic blocked;
        logic special;
        logic take;
        state_d     = state_q;
        hold_d      = hold_q;
        store_req_d = store_req_q;
        store_id_d  = store_id_q;
        flush_d     = 1'b0;
        flush_pc_d  = flush_pc_q;
        rob_dequeue = '0;
        rrf_we      = '0;
        blocked     = 1'b0;
        special     = 1'b0;
        take        = 1'b0;

        for (int j = 0; j < NSIZE; j++) begin
            rrf_rd[j] = rst_n ? rob_head[j].rd : '0;
            rrf_pd[j] = rst_n ? PR_BITS'(rob_head[j].pd) : '0;
        end

        case (state_q)
            COMMIT: begin
                for (int j = 0; j < NSIZE; j++) begin
                    special = rob_head[j].is_store | rob_head[j].br_mispredict;
                    take    = !blocked && ((DEPTH_BITS+1)'(j) < rob_elemcount)
                              && rob_head[j].ready && (j == 0 || !special);
                    // Stores wait at slot 0 for the memory ack before they dequeue.
                    if (take && j == 0 && rob_head[j].is_store) begin
                        store_req_d = 1'b1;
                        store_id_d  = rob_tail;
                        state_d     = STORE_WAIT;
                        take        = 1'b0;
                    end else if (take && j == 0 && rob_head[j].br_mispredict) begin
                        flush_d    = 1'b1;
                        flush_pc_d = rob_head[j].br_target;
                        hold_d     = HW'(FLUSH_HOLD);
                        state_d    = FLUSH;
                    end
                    if (take) begin
                        rob_dequeue[j] = 1'b1;
                        rrf_we[j]      = (rob_head[j].rd != 5'd0);
                    end
                    blocked = blocked | !take | special;
                end
            end
            STORE_WAIT: begin
                if (st.store_ack) begin
                    rob_dequeue[0] = 1'b1;
                    store_req_d    = 1'b0;
                    state_d        = COMMIT;
                end
            end
            FLUSH: begin
                hold_d = hold_q - 1'b1;
                if (hold_q <= HW'(1)) state_d = COMMIT;
            end
            default: state_d = COMMIT;
        endcase

        if (!rst_n) begin
            rob_dequeue = '0;
            rrf_we      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: every control register has a reset value; nothing here is a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COMMIT;
            hold_q      <= '0;
            store_req_q <= 1'b0;
            store_id_q  <= '0;
            flush_q     <= 1'b0;
            flush_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            store_req_q <= store_req_d;
            store_id_q  <= store_id_d;
            flush_q     <= flush_d;
            flush_pc_q  <= flush_pc_d;
        end
    end

    assign st.store_req    = store_req_q;
    assign st.store_rob_id = store_id_q;
    assign flush           = flush_q;
    assign flush_pc        = flush_pc_q;

`ifdef ROB_COMMIT_MONITOR_EN
    logic [63:0] order_q, order_d;

    assign mon_valid = rob_dequeue;

    always_comb begin
        order_d = order_q;
        for (int j = 0; j < NSIZE; j++) begin
            mon_order[j] = order_d;
            order_d      = order_d + 64'(rob_dequeue[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) order_q <= '0;
        else        order_q <= order_d;
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl; monitor checks need ROB_COMMIT_MONITOR_EN.
module tb_rob_commit_ctrl;
    import rv32i_types::*;

    logic       clk;
    logic       rst_n;
    rob_entry_t rob_head [2];
    logic [3:0] rob_elemcount;
    logic [2:0] rob_tail;
    logic [1:0] rob_dequeue;
    logic [1:0] rrf_we;
    logic [4:0] rrf_rd [2];
    logic [5:0] rrf_pd [2];
    logic       flush;
    logic [31:0] flush_pc;
`ifdef ROB_COMMIT_MONITOR_EN
    logic [1:0]  mon_valid;
    logic [63:0] mon_order [2];
`endif

    int checks   = 0;
    int failures = 0;

    rob_commit_ctrl_if #(.DEPTH_BITS(3)) sif ();

    rob_commit_ctrl #(
        .NSIZE(2), .DEPTH_BITS(3), .PR_BITS(6), .FLUSH_HOLD(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rob_head(rob_head),
        .rob_elemcount(rob_elemcount),
        .rob_tail(rob_tail),
        .rob_dequeue(rob_dequeue),
        .rrf_we(rrf_we),
        .rrf_rd(rrf_rd),
        .rrf_pd(rrf_pd),
        .st(sif),
        .flush(flush),
        .flush_pc(flush_pc)
`ifdef ROB_COMMIT_MONITOR_EN
        ,
        .mon_valid(mon_valid),
        .mon_order(mon_order)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic rob_entry_t alu(input logic [4:0] rd, input logic [5:0] pd);
        rob_entry_t e = '0;
        e.ready = 1'b1; e.rd = rd; e.pd = pd;
        return e;
    endfunction

    function automatic rob_entry_t store_e();
        rob_entry_t e = '0;
        e.ready = 1'b1; e.is_store = 1'b1;
        return e;
    endfunction

    function automatic rob_entry_t mispredict(input logic [4:0] rd, input logic [5:0] pd,
                                              input logic [31:0] tgt);
        rob_entry_t e = '0;
        e.ready = 1'b1; e.rd = rd; e.pd = pd; e.br_mispredict = 1'b1; e.br_target = tgt;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        sif.store_ack = 1'b0;
        rob_tail      = 3'd0;
        rob_head[0]   = alu(5'd1, 6'd10);
        rob_head[1]   = alu(5'd2, 6'd11);
        rob_elemcount = 4'd2;
        @(negedge clk);
        #1;
        check("rst_dequeue", 64'(rob_dequeue), 64'h0);
        check("rst_rrf_we", 64'(rrf_we), 64'h0);
        check("rst_store_req", 64'(sif.store_req), 64'h0);
        check("rst_store_id", 64'(sif.store_rob_id), 64'h0);
        check("rst_flush", 64'(flush), 64'h0);
        check("rst_flush_pc", 64'(flush_pc), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three ready ALU entries: two retire, then the third.
        rob_elemcount = 4'd3;
        #1;
        check("alu3_c0_dequeue", 64'(rob_dequeue), 64'h3);
        check("alu3_c0_we", 64'(rrf_we), 64'h3);
        check("alu3_c0_rd1", 64'(rrf_rd[1]), 64'd2);
        check("alu3_c0_pd0", 64'(rrf_pd[0]), 64'd10);
        step();
        rob_head[0] = alu(5'd3, 6'd12);
        rob_head[1] = '0;
        rob_elemcount = 4'd1;
        #1;
        check("alu3_c1_dequeue", 64'(rob_dequeue), 64'h1);
        check("alu3_c1_rd0", 64'(rrf_rd[0]), 64'd3);
        step();

        // rd==0 commits without an RRF write; unready slot 1 stops the window.
        rob_head[0] = alu(5'd0, 6'd5);
        rob_head[1] = '0;
        rob_elemcount = 4'd2;
        #1;
        check("rd0_dequeue", 64'(rob_dequeue), 64'h1);
        check("rd0_we", 64'(rrf_we), 64'h0);
        step();

        rob_elemcount = 4'd0;
        #1;
        check("empty_dequeue", 64'(rob_dequeue), 64'h0);
        step();
        rob_head[0] = '0;
        rob_head[1] = alu(5'd4, 6'd6);
        rob_elemcount = 4'd2;
        #1;
        check("slot0_unready_dequeue", 64'(rob_dequeue), 64'h0);
        step();

        // Store at head; an early ack is ignored, then three low cycles, then ack.
        rob_head[0] = store_e();
        rob_head[1] = alu(5'd4, 6'd6);
        rob_tail = 3'd5;
        sif.store_ack = 1'b1;
        #1;
        check("store_t0_dequeue", 64'(rob_dequeue), 64'h0);
        check("store_t0_req", 64'(sif.store_req), 64'h0);
        step();
        sif.store_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("store_wait_req", 64'(sif.store_req), 64'h1);
            check("store_wait_id", 64'(sif.store_rob_id), 64'd5);
            check("store_wait_dequeue", 64'(rob_dequeue), 64'h0);
            step();
        end
        sif.store_ack = 1'b1;
        #1;
        check("store_ack_req", 64'(sif.store_req), 64'h1);
        check("store_ack_dequeue", 64'(rob_dequeue), 64'h1);
        check("store_ack_we", 64'(rrf_we), 64'h0);
        step();
        sif.store_ack = 1'b0;
        rob_head[0] = alu(5'd4, 6'd6);
        rob_head[1] = '0;
        rob_elemcount = 4'd1;
        #1;
        check("store_done_req", 64'(sif.store_req), 64'h0);
        check("store_done_dequeue", 64'(rob_dequeue), 64'h1);
        step();

        // ALU then mispredict: the mispredict waits for slot 0, then flush and hold.
        rob_head[0] = alu(5'd6, 6'd20);
        rob_head[1] = mispredict(5'd7, 6'd21, 32'h6000_0040);
        rob_elemcount = 4'd2;
        #1;
        check("mp_c0_dequeue", 64'(rob_dequeue), 64'h1);
        step();
        rob_head[0] = mispredict(5'd7, 6'd21, 32'h6000_0040);
        rob_head[1] = alu(5'd8, 6'd22);
        #1;
        check("mp_c1_dequeue", 64'(rob_dequeue), 64'h1);
        check("mp_c1_we", 64'(rrf_we), 64'h1);
        check("mp_c1_rd0", 64'(rrf_rd[0]), 64'd7);
        check("mp_c1_flush", 64'(flush), 64'h0);
        step();
        rob_head[0] = alu(5'd8, 6'd22);
        rob_head[1] = alu(5'd9, 6'd23);
        #1;
        check("mp_c2_flush", 64'(flush), 64'h1);
        check("mp_c2_flush_pc", 64'(flush_pc), 64'h6000_0040);
        check("mp_c2_dequeue", 64'(rob_dequeue), 64'h0);
        check("mp_c2_we", 64'(rrf_we), 64'h0);
        step();
        #1;
        check("mp_c3_flush", 64'(flush), 64'h0);
        check("mp_c3_dequeue", 64'(rob_dequeue), 64'h0);
        step();
        #1;
        check("mp_c4_dequeue", 64'(rob_dequeue), 64'h3);
        step();

        // Asynchronous reset while waiting for a store ack.
        rob_head[0] = store_e();
        rob_head[1] = '0;
        rob_elemcount = 4'd1;
        rob_tail = 3'd3;
        #1;
        check("rstw_t0_dequeue", 64'(rob_dequeue), 64'h0);
        step();
        #1;
        check("rstw_req_before", 64'(sif.store_req), 64'h1);
        sif.store_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rstw_req_async", 64'(sif.store_req), 64'h0);
        check("rstw_id_async", 64'(sif.store_rob_id), 64'h0);
        check("rstw_dequeue_async", 64'(rob_dequeue), 64'h0);
        rst_n = 1'b1;
        #1;
        check("rstw_commit_state", 64'(rob_dequeue), 64'h0);
        step();
        check("rstw_req_redetect", 64'(sif.store_req), 64'h1);
        check("rstw_id_redetect", 64'(sif.store_rob_id), 64'd3);
        check("rstw_ack_dequeue", 64'(rob_dequeue), 64'h1);
        step();

        // Five commits since reset (1 store + 2 + 2), then a pair.
        sif.store_ack = 1'b0;
        rob_head[0] = alu(5'd10, 6'd30);
        rob_head[1] = alu(5'd11, 6'd31);
        rob_elemcount = 4'd4;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("mon_fill_dequeue", 64'(rob_dequeue), 64'h3);
            step();
        end
        #1;
        check("mon_next_dequeue", 64'(rob_dequeue), 64'h3);
`ifdef ROB_COMMIT_MONITOR_EN
        check("mon_valid", 64'(mon_valid), 64'h3);
        check("mon_order0", mon_order[0], 64'd5);
        check("mon_order1", mon_order[1], 64'd6);
`endif
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
